p_burst_line_adapter: RTL and testbench

Parametrised line/burst adapter between the cache's full-line memory port and the burst-oriented physical memory. It serialises a dirty line into BEATS bursts on write-back, and reassembles BEATS bursts into a full line on fill. Beat gaps (resp_i deasserted mid-transfer) are tolerated. Line-aligned addressing is generated internally. It sits between the cache datapath/control and the physical memory or arbiter.

---
 rtl/p_line_adapter_pkg.sv | 15 +
 rtl/p_burst_line_adapter.sv | 125 ++++++++++++
 tb/tb_p_burst_line_adapter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/p_line_adapter_pkg.sv
// Shared types and default widths for the cache line / memory burst adapter.
package p_line_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int LINE_W_DEF  = 256;
  localparam int BURST_W_DEF = 64;
  localparam int ADDR_W_DEF  = 32;

endpackage

// File: rtl/p_burst_line_adapter.sv
// Serialises a cache line into BEATS memory bursts on write-back and
// reassembles BEATS bursts into a full line on fill.
module p_burst_line_adapter
  import p_line_adapter_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic               read_o,
  output logic               write_o,
  output logic [ADDR_W-1:0]  address_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFS_W = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFS_W;

  if ((LINE_W % BURST_W) != 0 || BEATS < 2) begin : g_param_err
    $error("p_burst_line_adapter: LINE_W must be a multiple of BURST_W with at least 2 beats");
  end

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [LINE_W-1:0]  line_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [BURST_W-1:0] beat_slice [BEATS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read has priority over write when both are requested together.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (read_i) begin
          state_next = RD;
        end else if (write_i) begin
          state_next = WR;
        end
      end
      RD, WR: begin
        if (resp_i && cnt_reg == LAST_BEAT) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    case (state_reg)
      RD:      read_o  = 1'b1;
      WR:      write_o = 1'b1;
      DONE:    resp_o  = 1'b1;
      default: ;
    endcase
  end

  // The line buffer serves both directions: fill target and write-back source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      line_reg <= '0;
      addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (read_i || write_i) begin
            addr_reg <= address_i & ALIGN_MASK;
            cnt_reg  <= '0;
            if (!read_i) begin
              line_reg <= line_i;
            end
          end
        end
        RD: begin
          if (resp_i) begin
            line_reg[cnt_reg*BURST_W +: BURST_W] <= burst_i;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        WR: begin
          if (resp_i) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    assign beat_slice[gi] = line_reg[gi*BURST_W +: BURST_W];
  end

  assign burst_o   = beat_slice[cnt_reg];
  assign line_o    = line_reg;
  assign address_o = addr_reg;

endmodule

// File: tb/tb_p_burst_line_adapter.sv
// Directed bench for p_burst_line_adapter: vector table plus hand-written
// reset, idle-handshake and narrow-parameter sequences.
module tb_p_burst_line_adapter;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          read_i, write_i, resp_i;
  logic [AW-1:0] address_i, address_o;
  logic [LW-1:0] line_i, line_o;
  logic [BW-1:0] burst_i, burst_o;
  logic          resp_o, read_o, write_o;

  logic          b_read_i, b_write_i, b_resp_i;
  logic [31:0]   b_address_i, b_address_o;
  logic [127:0]  b_line_i, b_line_o;
  logic [31:0]   b_burst_i, b_burst_o;
  logic          b_resp_o, b_read_o, b_write_o;

  p_burst_line_adapter dut (
    .clk(clk), .rst(rst),
    .read_i(read_i), .write_i(write_i), .address_i(address_i), .line_i(line_i),
    .line_o(line_o), .resp_o(resp_o), .read_o(read_o), .write_o(write_o),
    .address_o(address_o), .burst_i(burst_i), .burst_o(burst_o), .resp_i(resp_i)
  );

  p_burst_line_adapter #(.LINE_W(128), .BURST_W(32), .ADDR_W(32)) dut_b (
    .clk(clk), .rst(rst),
    .read_i(b_read_i), .write_i(b_write_i), .address_i(b_address_i), .line_i(b_line_i),
    .line_o(b_line_o), .resp_o(b_resp_o), .read_o(b_read_o), .write_o(b_write_o),
    .address_o(b_address_o), .burst_i(b_burst_i), .burst_o(b_burst_o), .resp_i(b_resp_i)
  );

  typedef struct {
    bit             rd;
    bit             wr;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  data;      // write line, or read beats with beat 0 in the low bits
    int             gap_at;    // beat index after which resp_i drops; -1 for none
    int             gap_len;
    logic [AW-1:0]  exp_addr;
    logic [LW-1:0]  exp_line;
  } vec_t;

  vec_t vecs [5];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_active(input int b, input bit is_wr, input vec_t v);
    chk("read_o active", read_o, !is_wr);
    chk("write_o active", write_o, is_wr);
    chk("resp_o early", resp_o, 1'b0);
    chk("address_o", address_o, v.exp_addr);
    if (is_wr) chk("burst_o", burst_o, v.data[b*BW +: BW]);
  endtask

  // Entered at a negedge with the adapter idle; leaves at the negedge of the
  // idle cycle following resp_o with the request dropped.
  task automatic run_vec(input int idx, input vec_t v);
    bit is_wr;
    is_wr = !v.rd && v.wr;
    read_i    = v.rd;
    write_i   = v.wr;
    address_i = v.addr;
    line_i    = v.data;
    resp_i    = 1'b0;
    @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      if (b > 0 && (b - 1) == v.gap_at) begin
        for (int g = 0; g < v.gap_len; g++) begin
          check_active(b, is_wr, v);
          resp_i  = 1'b0;
          burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
          @(negedge clk);
        end
      end
      check_active(b, is_wr, v);
      resp_i  = 1'b1;
      burst_i = is_wr ? 64'h0 : v.data[b*BW +: BW];
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("resp_o done", resp_o, 1'b1);
    chk("read_o done", read_o, 1'b0);
    chk("write_o done", write_o, 1'b0);
    chk("line_o", line_o, v.exp_line);
    @(negedge clk);
    chk("resp_o single", resp_o, 1'b0);
    chk("read_o idle", read_o, 1'b0);
    chk("write_o idle", write_o, 1'b0);
    read_i  = 1'b0;
    write_i = 1'b0;
    $display("TXN %0d %s addr=%h aligned=%h line=%h", idx, is_wr ? "WR" : "RD",
             v.addr, v.exp_addr, v.exp_line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t fresh;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234,
                256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                -1, 0, 32'h0000_1220,
                256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
    vecs[1] = '{1'b0, 1'b1, 32'h8000_0047,
                256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A55A5A5A5A_7766554489ABCDEF,
                1, 2, 32'h8000_0040,
                256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A55A5A5A5A_7766554489ABCDEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_00FF,
                256'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7_C0C1C2C3C4C5C6C7_D0D1D2D3D4D5D6D7,
                0, 1, 32'h0000_00E0,
                256'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7_C0C1C2C3C4C5C6C7_D0D1D2D3D4D5D6D7};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF,
                256'hFEDCBA9876543210_0F1E2D3C4B5A6978_1122334455667788_99AABBCCDDEEFF00,
                2, 3, 32'hFFFF_FFE0,
                256'hFEDCBA9876543210_0F1E2D3C4B5A6978_1122334455667788_99AABBCCDDEEFF00};
    vecs[4] = '{1'b1, 1'b0, 32'h1000_0020,
                256'h8877665544332211_1020304050607080_0102030405060708_F1F2F3F4F5F6F7F8,
                -1, 0, 32'h1000_0020,
                256'h8877665544332211_1020304050607080_0102030405060708_F1F2F3F4F5F6F7F8};

    rst = 1'b1;
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    b_read_i = 1'b0; b_write_i = 1'b0; b_resp_i = 1'b0;
    b_address_i = '0; b_line_i = '0; b_burst_i = '0;
    repeat (2) @(negedge clk);
    chk("reset read_o", read_o, 1'b0);
    chk("reset write_o", write_o, 1'b0);
    chk("reset resp_o", resp_o, 1'b0);
    chk("reset address_o", address_o, 32'h0);
    chk("reset line_o", line_o, 256'h0);
    chk("reset burst_o", burst_o, 64'h0);
    chk("reset b_line_o", b_line_o, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // Beat handshakes while idle must not be taken.
    resp_i  = 1'b1;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("idle resp_i read_o", read_o, 1'b0);
    chk("idle resp_i line_o", line_o, 256'h0);
    resp_i = 1'b0;
    $display("TXN idle handshake ignored");

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Asynchronous reset after two fill beats.
    read_i = 1'b1;
    address_i = 32'h0000_0040;
    @(negedge clk);
    resp_i = 1'b1; burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
    @(negedge clk);
    burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
    @(negedge clk);
    resp_i = 1'b0;
    read_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midreset read_o", read_o, 1'b0);
    chk("midreset resp_o", resp_o, 1'b0);
    chk("midreset address_o", address_o, 32'h0);
    chk("midreset line_o", line_o, 256'h0);
    chk("midreset burst_o", burst_o, 64'h0);
    $display("TXN reset mid-fill");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fresh = '{1'b1, 1'b0, 32'h0000_0067,
              256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001,
              -1, 0, 32'h0000_0060,
              256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001};
    run_vec(5, fresh);

    // Narrow instance: 128-bit line, 32-bit bursts, 16-byte alignment.
    b_read_i = 1'b1;
    b_address_i = 32'hABCD_EF1F;
    @(negedge clk);
    chk("b read_o", b_read_o, 1'b1);
    chk("b address_o", b_address_o, 32'hABCD_EF10);
    for (int b = 0; b < 4; b++) begin
      chk("b resp_o early", b_resp_o, 1'b0);
      b_resp_i = 1'b1;
      b_burst_i = {4{8'(8'h0A + b)}};
      @(negedge clk);
    end
    b_resp_i = 1'b0;
    chk("b resp_o", b_resp_o, 1'b1);
    chk("b read_o done", b_read_o, 1'b0);
    chk("b line_o", b_line_o, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    @(negedge clk);
    chk("b resp_o single", b_resp_o, 1'b0);
    b_read_i = 1'b0;
    $display("TXN narrow RD addr=%h aligned=%h line=%h", 32'hABCD_EF1F, b_address_o, b_line_o);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
